// File: rtl/operand_streamer.sv
// Streams pixel (A) and weight (B) operands to the conv engine, one A then one B per MAC,
// walking x / y / ch_in / ch_out / k_v / k_h and supplying zeros for padded pixels.
module operand_streamer #(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FM_ADDR_WIDTH      = 26,
  parameter int K_ADDR_WIDTH       = 17
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     start,
  output logic                     running,
  output logic                     done,
  input  logic [1:0]               conv_kernel_mode,
  input  logic [1:0]               conv_stride_mode,
  output logic                     fm_re,
  output logic [FM_ADDR_WIDTH-1:0] fm_addr,
  input  logic [DATA_WIDTH-1:0]    fm_rdata,
  output logic                     k_re,
  output logic [K_ADDR_WIDTH-1:0]  k_addr,
  input  logic [DATA_WIDTH-1:0]    k_rdata,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [DATA_WIDTH-1:0]    a_data,
  output logic                     b_valid,
  input  logic                     b_ready,
  output logic [DATA_WIDTH-1:0]    b_data
);

  // state  | meaning
  // IDLE   | waiting for start
  // READ_A | feature read issued (skipped when the pixel is padding)
  // LOAD_A | capture pixel or zero into a_data
  // SEND_A | a_valid held until a_ready
  // READ_B | kernel read issued
  // LOAD_B | capture weight into b_data
  // SEND_B | b_valid held until b_ready; counters step on the handshake

  localparam int W   = FEATURE_MAP_WIDTH;
  localparam int H   = FEATURE_MAP_HEIGHT;
  localparam int CIN = INPUT_NB_CHANNELS;
  localparam int COUT = OUTPUT_NB_CHANNELS;
  localparam int XW  = $clog2(W);
  localparam int YW  = $clog2(H);
  localparam int CIW = $clog2(CIN > 1 ? CIN : 2);
  localparam int COW = $clog2(COUT > 1 ? COUT : 2);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_A, S_LOAD_A, S_SEND_A, S_READ_B, S_LOAD_B, S_SEND_B
  } state_t;

  state_t state_q, state_d;

  logic [1:0]     kmode_q, smode_q;
  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic [CIW-1:0] ch_in_q;
  logic [COW-1:0] ch_out_q;
  logic [2:0]     k_v_q, k_h_q;

  logic [2:0] k_max, stride;
  logic       kh_last, kv_last, cho_last, chi_last, y_last, x_last, last_mac;
  logic       in_range, b_hs;
  int         ix, iy, fm_lin, k_lin;

  always_comb begin
    k_max    = {kmode_q, 1'b0};
    stride   = 3'd1 << smode_q;
    kh_last  = (k_h_q == k_max);
    kv_last  = (k_v_q == k_max);
    cho_last = (int'(ch_out_q) == COUT - 1);
    chi_last = (int'(ch_in_q) == CIN - 1);
    y_last   = (int'(y_q) >= H - int'(stride));
    x_last   = (int'(x_q) >= W - int'(stride));
    last_mac = kh_last && kv_last && cho_last && chi_last && y_last && x_last;
    // padding offset P equals the kernel mode (K = 2*mode+1)
    ix       = int'(x_q) + int'(k_h_q) - int'(kmode_q);
    iy       = int'(y_q) + int'(k_v_q) - int'(kmode_q);
    in_range = (ix >= 0) && (ix < W) && (iy >= 0) && (iy < H);
    fm_lin   = (int'(ch_in_q) * H + iy) * W + ix;
    k_lin    = ((int'(ch_out_q) * CIN + int'(ch_in_q)) * 5 + int'(k_v_q)) * 5 + int'(k_h_q);
    b_hs     = (state_q == S_SEND_B) && b_ready;
  end

  always_ff @(posedge clk) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_READ_A;
      S_READ_A: state_d = S_LOAD_A;
      S_LOAD_A: state_d = S_SEND_A;
      S_SEND_A: if (a_ready) state_d = S_READ_B;
      S_READ_B: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_SEND_B;
      S_SEND_B: if (b_ready) state_d = last_mac ? S_IDLE : S_READ_A;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    running = (state_q != S_IDLE);
    fm_re   = (state_q == S_READ_A) && in_range;
    fm_addr = fm_re ? FM_ADDR_WIDTH'(fm_lin) : '0;
    k_re    = (state_q == S_READ_B);
    k_addr  = k_re ? K_ADDR_WIDTH'(k_lin) : '0;
    a_valid = (state_q == S_SEND_A);
    b_valid = (state_q == S_SEND_B);
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      kmode_q  <= '0;
      smode_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ch_in_q  <= '0;
      ch_out_q <= '0;
      k_v_q    <= '0;
      k_h_q    <= '0;
      a_data   <= '0;
      b_data   <= '0;
      done     <= 1'b0;
    end else begin
      done <= b_hs && last_mac;
      if (state_q == S_IDLE && start) begin
        kmode_q <= (conv_kernel_mode == 2'd3) ? 2'd2 : conv_kernel_mode;
        smode_q <= (conv_stride_mode == 2'd3) ? 2'd2 : conv_stride_mode;
      end
      if (state_q == S_LOAD_A) a_data <= in_range ? fm_rdata : '0;
      if (state_q == S_LOAD_B) b_data <= k_rdata;
      // after the final MAC every counter wraps back to zero
      if (b_hs) begin
        if (kh_last) begin
          k_h_q <= '0;
          if (kv_last) begin
            k_v_q <= '0;
            if (cho_last) begin
              ch_out_q <= '0;
              if (chi_last) begin
                ch_in_q <= '0;
                if (y_last) begin
                  y_q <= '0;
                  if (x_last) x_q <= '0;
                  else        x_q <= x_q + XW'(stride);
                end else begin
                  y_q <= y_q + YW'(stride);
                end
              end else begin
                ch_in_q <= ch_in_q + CIW'(1);
              end
            end else begin
              ch_out_q <= ch_out_q + COW'(1);
            end
          end else begin
            k_v_q <= k_v_q + 3'd1;
          end
        end else begin
          k_h_q <= k_h_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_streamer.sv
// Directed bench for operand_streamer on a 4x4x2->2 map; a loop-nest model predicts every
// operand, address and padding decision, and per-layer cycle counts are hand-computed.
module tb_operand_streamer;
  localparam int W = 4, H = 4, CI = 2, CO = 2, DW = 16, FAW = 26, KAW = 17;
  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_in, start, running, done;
  logic [1:0]     conv_kernel_mode, conv_stride_mode;
  logic           fm_re, k_re, a_valid, a_ready, b_valid, b_ready;
  logic [FAW-1:0] fm_addr;
  logic [KAW-1:0] k_addr;
  logic [DW-1:0]  fm_rdata, k_rdata, a_data, b_data;

  operand_streamer #(
    .DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
    .INPUT_NB_CHANNELS(CI), .OUTPUT_NB_CHANNELS(CO),
    .FM_ADDR_WIDTH(FAW), .K_ADDR_WIDTH(KAW)
  ) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .running(running), .done(done),
    .conv_kernel_mode(conv_kernel_mode), .conv_stride_mode(conv_stride_mode),
    .fm_re(fm_re), .fm_addr(fm_addr), .fm_rdata(fm_rdata),
    .k_re(k_re), .k_addr(k_addr), .k_rdata(k_rdata),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data)
  );

  logic [DW-1:0] fm_mem [W*H*CI];
  logic [DW-1:0] k_mem  [CO*CI*25];

  always @(posedge clk) begin
    if (fm_re) fm_rdata <= (fm_addr < FAW'(W*H*CI)) ? fm_mem[fm_addr] : 16'hdead;
    if (k_re)  k_rdata  <= (k_addr < KAW'(CO*CI*25)) ? k_mem[k_addr] : 16'hbeef;
  end

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    bit            inr;
    int            fa;
    int            ka;
  } mac_t;
  mac_t q[$];

  int n_chk = 0, n_bad = 0;
  bit mon_en = 0;
  bit fm_re_seen = 0;
  int a_hs, b_hs, done_cnt, last_k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_model(input logic [1:0] km, input logic [1:0] sm);
    int kmi, smi, kk, ss;
    kmi = (km == 2'd3) ? 2 : int'(km);
    smi = (sm == 2'd3) ? 2 : int'(sm);
    kk  = 2 * kmi + 1;
    ss  = 1 << smi;
    q.delete();
    for (int x = 0; x < W; x += ss)
      for (int y = 0; y < H; y += ss)
        for (int ci = 0; ci < CI; ci++)
          for (int co = 0; co < CO; co++)
            for (int kv = 0; kv < kk; kv++)
              for (int kh = 0; kh < kk; kh++) begin
                mac_t m;
                int ix, iy;
                ix    = x + kh - kmi;
                iy    = y + kv - kmi;
                m.inr = (ix >= 0) && (ix < W) && (iy >= 0) && (iy < H);
                m.fa  = m.inr ? (ci * H + iy) * W + ix : 0;
                m.ka  = ((co * CI + ci) * 5 + kv) * 5 + kh;
                m.a   = m.inr ? fm_mem[m.fa] : '0;
                m.b   = k_mem[m.ka];
                q.push_back(m);
              end
  endtask

  // observe the bus mid-cycle; valid && ready here means a transfer on the coming edge
  always @(negedge clk) begin
    if (mon_en && !rst_in) begin
      if (done) done_cnt++;
      if (fm_re) begin
        fm_re_seen = 1;
        if (q.size() > 0) chk("fm_addr", fm_addr, q[0].fa);
      end
      if (k_re) begin
        last_k = int'(k_addr);
        if (q.size() > 0) chk("k_addr", k_addr, q[0].ka);
      end
      if (a_valid && a_ready) begin
        a_hs++;
        chk("a_excl_b", b_valid, 0);
        chk("a_pending", q.size() > 0, 1);
        if (q.size() > 0) begin
          chk("a_data", a_data, q[0].a);
          chk("a_fm_read", fm_re_seen, q[0].inr);
        end
        fm_re_seen = 0;
      end
      if (b_valid && b_ready) begin
        b_hs++;
        chk("b_excl_a", a_valid, 0);
        chk("b_pending", q.size() > 0, 1);
        if (q.size() > 0) begin
          chk("b_data", b_data, q[0].b);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_re"}, {fm_re, k_re}, 0);
    chk({tag, "_valid"}, {a_valid, b_valid}, 0);
    chk({tag, "_a_data"}, a_data, 0);
    chk({tag, "_b_data"}, b_data, 0);
    chk({tag, "_fm_addr"}, fm_addr, 0);
    chk({tag, "_k_addr"}, k_addr, 0);
  endtask

  task automatic run_layer(input logic [1:0] km, input logic [1:0] sm, input int exp_cyc,
                           input bit perturb, input bit stall);
    int n_exp, cyc, st_cnt;
    logic [DW-1:0] held;
    build_model(km, sm);
    n_exp    = q.size();
    a_hs     = 0;
    b_hs     = 0;
    done_cnt = 0;
    st_cnt   = 0;
    held     = '0;
    fm_re_seen = 0;
    a_ready  = !stall;
    b_ready  = 1'b1;
    @(posedge clk); #1;
    conv_kernel_mode = km;
    conv_stride_mode = sm;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk("running_after_start", running, 1);
    while (!done && cyc < LIMIT) begin
      if (perturb && cyc == 50) begin
        start = 1'b1;
        conv_kernel_mode = 2'd0;
        conv_stride_mode = 2'd0;
      end
      if (perturb && cyc == 51) start = 1'b0;
      if (stall && st_cnt < 5 && (st_cnt > 0 || a_valid)) begin
        chk("stall_a_valid", a_valid, 1);
        if (st_cnt == 0) held = a_data;
        else chk("stall_a_data", a_data, held);
        chk("stall_reads", {fm_re, k_re}, 0);
        st_cnt++;
        if (st_cnt == 5) a_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", done, 1);
    chk("done_cycle", cyc, exp_cyc);
    chk("running_at_done", running, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("a_handshakes", a_hs, n_exp);
    chk("b_handshakes", b_hs, n_exp);
    chk("done_pulses", done_cnt, 1);
    chk("model_drained", q.size(), 0);
    chk("idle_after", running, 0);
  endtask

  initial begin
    for (int i = 0; i < W * H * CI; i++) fm_mem[i] = DW'(16'h1000 + i);
    for (int i = 0; i < CO * CI * 25; i++) k_mem[i] = DW'(16'h2000 + i);
    rst_in = 1'b1;
    start = 1'b0;
    conv_kernel_mode = 2'd0;
    conv_stride_mode = 2'd0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_in = 1'b0;
    check_idle("reset");

    // reset in the middle of traffic, then relaunch
    a_ready = 1'b1;
    b_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_in = 1'b1;
    @(posedge clk); #1 rst_in = 1'b0;
    check_idle("midrst");
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("restart_fm_re", fm_re, 1);
    chk("restart_fm_addr", fm_addr, 0);
    rst_in = 1'b1;
    @(posedge clk); #1 rst_in = 1'b0;
    check_idle("rst2");

    mon_en = 1;
    run_layer(2'd0, 2'd0, 385, 0, 0);    // 1x1, 64 MACs
    run_layer(2'd1, 2'd0, 3457, 0, 0);   // 3x3 with padding, 576 MACs
    run_layer(2'd0, 2'd0, 389, 0, 1);    // 1x1 with a 5-cycle a_ready stall
    run_layer(2'd2, 2'd1, 2401, 0, 0);   // 5x5 stride 2, 400 MACs
    chk("final_k_addr", last_k, 99);
    run_layer(2'd1, 2'd1, 865, 1, 0);    // 3x3 stride 2, start/modes poked mid-layer

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
